// File: rtl/shift_add_mul_4b.sv
// shift_add_mul_4b: sequential 4x4 shift-and-add multiplier.
// One 4-bit add-with-carry per CALC cycle, four CALC cycles per product,
// start/done handshake, registered product and zero flag.
// Build option: define MUL_SIGNED_EN for two's-complement operands
// (magnitudes are multiplied, the sign is reapplied on commit).
module shift_add_mul_4b (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic       zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] mcand, mplr;
    logic [8:0] acc, acc_step;
    logic [1:0] cnt;
    logic [4:0] add_sum;
    logic [3:0] a_mag, b_mag;
    logic [7:0] commit_val;
    logic       commit;

`ifdef MUL_SIGNED_EN
    logic neg;

    // Operand magnitudes; -8 maps to 4'b1000, which is still a valid unsigned 8
    always_comb begin
        a_mag = a[3] ? (4'd0 - a) : a;
        b_mag = b[3] ? (4'd0 - b) : b;
    end
`else
    // Unsigned build: operands go straight into the datapath
    always_comb begin
        a_mag = a;
        b_mag = b;
    end
`endif

    // One shift-add step: add mcand into the upper nibble when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    // acc[8] is always zero after a shift, so shifting all 9 bits is the same
    // as shifting {1'b0, acc[7:0]}.
    always_comb begin
        add_sum  = {1'b0, acc[7:4]} + {1'b0, mcand};
        acc_step = mplr[0] ? ({add_sum, acc[3:0]} >> 1) : (acc >> 1);
        commit   = (state == CALC) && (cnt == 2'd3);
    end

`ifdef MUL_SIGNED_EN
    // Reapply the sign to the magnitude product on the final step
    always_comb begin
        commit_val = neg ? (8'd0 - acc_step[7:0]) : acc_step[7:0];
    end
`else
    // Final step result is the product as-is
    always_comb begin
        commit_val = acc_step[7:0];
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs (decoded from the state register only)
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (cnt == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept, shift-add iteration during CALC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand <= 4'd0;
            mplr  <= 4'd0;
            acc   <= 9'd0;
            cnt   <= 2'd0;
`ifdef MUL_SIGNED_EN
            neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    mcand <= a_mag;
                    mplr  <= b_mag;
                    acc   <= 9'd0;
                    cnt   <= 2'd0;
`ifdef MUL_SIGNED_EN
                    neg   <= a[3] ^ b[3];
`endif
                end
                CALC: begin
                    acc  <= acc_step;
                    mplr <= mplr >> 1;
                    cnt  <= cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Result registers: written only on the fourth CALC edge, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= 8'h00;
            zero    <= 1'b1;
        end else if (commit) begin
            product <= commit_val;
            zero    <= (commit_val == 8'h00);
        end
    end

endmodule
